// File: rtl/cmp_pkg.sv
// Shared types and result encoding for the sequential magnitude comparator.
// Results are one-hot in {lt, gt, eq} order.
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for a debounced button level.
// History resets to 1 so a button held through reset does not register as a press.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic q;

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b1;
    else     q <= in;
  end

  assign pulse = in & ~q;

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Chunk-loaded operands compared MSB-first, one bit per cycle, stopping at the
// first differing bit; the result holds until the next accepted start.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int CHUNK  = 4,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CSW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1,
  localparam int BW     = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CHUNK-1:0] din,
  input  logic             load,
  input  logic             op_sel,
  input  logic [CSW-1:0]   chunk_sel,
  input  logic             signed_mode,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [BW-1:0]    bits_used
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  logic load_edge, start_edge;

  edge_rise u_load_edge  (.clk(clk), .rst(rst), .in(load),  .pulse(load_edge));
  edge_rise u_start_edge (.clk(clk), .rst(rst), .in(start), .pulse(start_edge));

  state_t           state, state_n;
  logic [WIDTH-1:0] a, a_n, b, b_n;
  logic [IW-1:0]    idx, idx_n;
  logic             smode, smode_n;
  logic [2:0]       res, res_n;
  logic             busy_n, done_n;
  logic [BW-1:0]    bits_n;
  logic             abit, bbit, a_greater;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      idx       <= '0;
      smode     <= 1'b0;
      res       <= RES_NONE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bits_used <= '0;
    end else begin
      state     <= state_n;
      a         <= a_n;
      b         <= b_n;
      idx       <= idx_n;
      smode     <= smode_n;
      res       <= res_n;
      busy      <= busy_n;
      done      <= done_n;
      bits_used <= bits_n;
    end
  end

  always_comb begin
    state_n   = state;
    a_n       = a;
    b_n       = b;
    idx_n     = idx;
    smode_n   = smode;
    res_n     = res;
    busy_n    = busy;
    done_n    = 1'b0;
    bits_n    = bits_used;
    abit      = a[idx];
    bbit      = b[idx];
    // In signed mode the sign bit carries inverted weight.
    a_greater = abit ^ (smode & (idx == IDX_TOP));

    case (state)
      IDLE: begin
        if (load_edge) begin
          for (int k = 0; k < NCHUNK; k++) begin
            if (chunk_sel == CSW'(k)) begin
              if (op_sel) b_n[k*CHUNK +: CHUNK] = din;
              else        a_n[k*CHUNK +: CHUNK] = din;
            end
          end
        end
        if (start_edge) begin
          state_n = RUN;
          idx_n   = IDX_TOP;
          smode_n = signed_mode;
          res_n   = RES_NONE;
          busy_n  = 1'b1;
          bits_n  = '0;
        end
      end
      RUN: begin
        bits_n = bits_used + 1'b1;
        if (abit != bbit) begin
          res_n   = a_greater ? RES_GT : RES_LT;
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else if (idx == '0) begin
          res_n   = RES_EQ;
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          idx_n = idx - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign lt = res[2];
  assign gt = res[1];
  assign eq = res[0];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: vector table, directed corner sequences
// and randomized operands checked against an arithmetic reference model.
module tb_seq_magnitude_comparator;

  localparam int WIDTH = 8;
  localparam int CHUNK = 4;
  localparam logic [2:0] R_LT = 3'b100;
  localparam logic [2:0] R_GT = 3'b010;
  localparam logic [2:0] R_EQ = 3'b001;

  logic       clk = 1'b0;
  logic       rst, load, op_sel, chunk_sel, signed_mode, start;
  logic [3:0] din;
  logic       busy, done, lt, gt, eq;
  logic [3:0] bits_used;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .din(din), .load(load), .op_sel(op_sel),
    .chunk_sel(chunk_sel), .signed_mode(signed_mode), .start(start),
    .busy(busy), .done(done), .lt(lt), .gt(gt), .eq(eq), .bits_used(bits_used)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sm;
    logic [2:0] res;
    int         bits;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press_load(input logic op, input logic cs, input logic [3:0] d);
    @(negedge clk);
    op_sel = op; chunk_sel = cs; din = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
    press_load(1'b0, 1'b0, a[3:0]);
    press_load(1'b0, 1'b1, a[7:4]);
    press_load(1'b1, 1'b0, b[3:0]);
    press_load(1'b1, 1'b1, b[7:4]);
  endtask

  // Called right after the negedge where start went high; the following
  // posedge samples the start edge.
  task automatic wait_result(input string tag, input logic [2:0] eres, input int ebits);
    int  n;
    int  busy_hi;
    bit  seen;
    @(negedge clk);
    start = 1'b0; load = 1'b0; signed_mode = ~signed_mode;
    n = 1; busy_hi = int'(busy); seen = (done === 1'b1);
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      busy_hi += int'(busy);
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      check({tag, "_latency"}, n - 1, ebits);
      check({tag, "_busy_cycles"}, busy_hi, ebits);
      check({tag, "_result"}, int'({lt, gt, eq}), int'(eres));
      check({tag, "_bits_used"}, int'(bits_used), ebits);
      @(negedge clk);
      check({tag, "_done_pulse"}, int'(done), 0);
      check({tag, "_hold"}, int'({lt, gt, eq}), int'(eres));
    end
  endtask

  task automatic run_compare(input string tag, input logic sm, input logic [2:0] eres, input int ebits);
    @(negedge clk);
    signed_mode = sm; start = 1'b1;
    wait_result(tag, eres, ebits);
  endtask

  // Reference: ordinary integer comparison; bits examined run from the MSB
  // down to the highest differing bit.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       output logic [2:0] res, output int bits);
    int ia, ib;
    logic [7:0] x;
    ia = sm ? int'($signed(a)) : int'(a);
    ib = sm ? int'($signed(b)) : int'(b);
    res = (ia < ib) ? R_LT : (ia > ib) ? R_GT : R_EQ;
    x = a ^ b;
    bits = WIDTH;
    for (int k = 0; k < WIDTH; k++) if (x[k]) bits = WIDTH - k;
  endtask

  vec_t vecs[8];

  initial begin
    int dc;
    vecs[0] = '{8'h80, 8'h01, 1'b0, R_GT, 1};
    vecs[1] = '{8'h80, 8'h01, 1'b1, R_LT, 1};
    vecs[2] = '{8'h5A, 8'h5A, 1'b0, R_EQ, 8};
    vecs[3] = '{8'h35, 8'h37, 1'b0, R_LT, 7};
    vecs[4] = '{8'hFF, 8'h7F, 1'b1, R_LT, 1};
    vecs[5] = '{8'hFE, 8'hFF, 1'b1, R_LT, 8};
    vecs[6] = '{8'h7F, 8'h80, 1'b0, R_LT, 1};
    vecs[7] = '{8'hC3, 8'hC1, 1'b1, R_GT, 7};

    // Buttons held through reset must not act on release.
    rst = 1'b1; load = 1'b1; start = 1'b1; op_sel = 1'b0; chunk_sel = 1'b0;
    din = 4'hF; signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_bits", int'(bits_used), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("held_busy", int'(busy), 0);
    check("held_done", int'(done), 0);
    check("held_result", int'({lt, gt, eq}), 0);
    check("held_bits", int'(bits_used), 0);
    check("held_done_cnt", done_cnt, 0);
    load = 1'b0; start = 1'b0;
    @(negedge clk);
    run_compare("zero_ops", 1'b0, R_EQ, 8);

    foreach (vecs[i]) begin
      load_ops(vecs[i].a, vecs[i].b);
      run_compare($sformatf("vec%0d", i), vecs[i].sm, vecs[i].res, vecs[i].bits);
    end

    // Load and second start while running are both ignored.
    load_ops(8'h35, 8'h37);
    @(negedge clk);
    signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc = done_cnt;
    @(negedge clk);
    press_load(1'b1, 1'b0, 4'h0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("run_ignore_done_cnt", done_cnt - dc, 1);
    check("run_ignore_result", int'({lt, gt, eq}), int'(R_LT));
    check("run_ignore_bits", int'(bits_used), 7);

    // Simultaneous load and start: compare sees the new B = 0x5B.
    load_ops(8'h5A, 8'h5A);
    @(negedge clk);
    op_sel = 1'b1; chunk_sel = 1'b0; din = 4'hB; load = 1'b1;
    signed_mode = 1'b0; start = 1'b1;
    wait_result("simul_load_start", R_LT, 8);

    // Reset in the middle of a compare.
    load_ops(8'h01, 8'h00);
    @(negedge clk);
    signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dc = done_cnt;
    check("midrst_busy", int'(busy), 0);
    check("midrst_result", int'({lt, gt, eq}), 0);
    check("midrst_bits", int'(bits_used), 0);
    repeat (12) @(negedge clk);
    check("midrst_no_done", done_cnt - dc, 0);
    check("midrst_still_idle", int'(busy), 0);
    run_compare("midrst_cleared_ops", 1'b0, R_EQ, 8);
    load_ops(8'h01, 8'h00);
    run_compare("midrst_reload", 1'b0, R_GT, 8);

    // Randomized operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic       rs;
      logic [2:0] eres;
      int         ebits;
      ra = 8'($urandom_range(0, 255));
      case (i % 4)
        0:       rb = ra;
        1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
        default: rb = 8'($urandom_range(0, 255));
      endcase
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, eres, ebits);
      load_ops(ra, rb);
      run_compare($sformatf("rand%0d", i), rs, eres, ebits);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Parametrised, clocked successor to the 8-bit push-button comparator.
- Operands A and B, each WIDTH bits, are loaded CHUNK bits at a time through a shared data input using edge-detected load strobes.
- A start strobe launches an MSB-first bit-serial compare with early termination, in unsigned or two's-complement mode.
- Results (lt/gt/eq) are held until the next start; sits between the board switch/button front end and the LED/display logic.

Parameters:
- WIDTH, 8: operand width in bits; must be a multiple of CHUNK, WIDTH >= 2.
- CHUNK, 4: bits loaded per load strobe (matches the 4 data switches).
- NCHUNK, WIDTH/CHUNK: derived, not overridable; chunks per operand.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  CHUNK  chunk data to load.
- load  in  1  level from debounced button; acts on 0->1 transition only.
- op_sel  in  1  0 = load into A, 1 = load into B.
- chunk_sel  in  max(1,$clog2(NCHUNK))  chunk index; 0 = least-significant chunk.
- signed_mode  in  1  0 = unsigned, 1 = two's complement; sampled on the start edge.
- start  in  1  level from debounced button; acts on 0->1 transition only.
- busy  out  1  high while comparing.
- done  out  1  one-cycle pulse when the result becomes valid.
- lt  out  1  A < B.
- gt  out  1  A > B.
- eq  out  1  A == B.
- bits_used  out  $clog2(WIDTH)+1  number of bit positions examined for the last result (1..WIDTH).

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high. While rst is high at a clk edge:
  - A = B = 0; state IDLE.
  - busy, done, lt, gt, eq = 0; bits_used = 0.
  - Edge-detect history registers set to 1, so a button held through reset is not treated as a press.
- Edges: load_edge = load & ~load_q; start_edge = start & ~start_q. load_q and start_q register the raw inputs every cycle.
- Loading:
  - On load_edge in IDLE, the selected operand's bits [chunk_sel*CHUNK +: CHUNK] take din.
  - chunk_sel >= NCHUNK: the load is ignored.
  - Load edges during RUN are ignored; operands are frozen while busy.
- States:
  - IDLE: on start_edge -> RUN, idx = WIDTH-1, latch signed_mode, clear lt/gt/eq, busy = 1, bits_used = 0.
  - RUN: each cycle compares A[idx] and B[idx] and increments bits_used.
    - Bits differ: gt = A[idx] & ~B[idx], lt = ~A[idx] & B[idx]. At idx = WIDTH-1 in signed mode the sense is inverted (a set sign bit means smaller).
    - Bits differ -> IDLE: busy = 0, done = 1.
    - Bits equal and idx == 0 -> eq = 1, IDLE, busy = 0, done = 1.
    - Otherwise idx decrements.
  - Exactly one of lt/gt/eq is high after done; all three are low while busy.
- Latency: if n = number of bit positions examined, done is high in the cycle following the n-th clock edge after the edge that sampled start_edge. For WIDTH = 8: 1 to 8 cycles.
- done is a single-cycle pulse. lt/gt/eq/bits_used hold until the next accepted start_edge or reset.
- Simultaneous load_edge and start_edge in IDLE: the load is written at the same edge, and the compare uses the updated operand (RUN reads registers from the next cycle).
- start_edge during RUN is ignored; no restart.
- signed_mode changes during RUN have no effect.
- rst high mid-RUN: immediate return to the reset state; no done pulse.

Decomposition:
- Package cmp_pkg: state enum (IDLE, RUN) and the result-encoding constants RES_LT, RES_GT, RES_EQ.
- Sub-module edge_rise (1-bit rising-edge detector, reset value 1, ports clk/rst/in/pulse), instantiated for load and start.
- The datapath stays in the top module.

Test Plan:
- Reset with load and start held high, then release and re-assert nothing -> no load, no compare; A = B = 0, all outputs 0.
- Unsigned, A = 0x80, B = 0x01 (loaded as four chunk writes), start -> gt = 1, bits_used = 1, done pulses 1 cycle after the start-sampling edge.
- Signed, same operands -> lt = 1, bits_used = 1.
- Unsigned, A = 0x5A, B = 0x5A -> eq = 1, bits_used = 8, done 8 cycles after start; busy high exactly 8 cycles.
- Unsigned, A = 0x35, B = 0x37 -> lt = 1, bits_used = 7.
  - Load B chunk 0 = 0x0 during RUN: ignored, result unchanged.
  - Second start during RUN: ignored.
- Assert rst at cycle 3 of a compare of A = 0x01, B = 0x00 -> no done pulse; outputs 0; next start after reloading compares from a clean state.
